segmentos_a_letras: RTL and testbench

SEGMENTOS_A_LETRAS -- requirements
Module: segmentos_a_letras

---
 rtl/segmentos_pkg.sv | 50 +++++
 rtl/segmentos_decod.sv | 34 +++
 rtl/segmentos_a_letras.sv | 171 +++++++++++++++++
 tb/tb_segmentos_a_letras.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/segmentos_pkg.sv
// segmentos_pkg
// Shared constants for the seven-segment-to-ASCII phrase detector:
//   - active-low segment patterns (bit6..bit0 = g,f,e,d,c,b,a)
//   - ASCII codes of the recognised symbols
//   - the 16-symbol expected phrase "POLO-SOLA-COSAS "
//   - matcher FSM state type and encodings
//   - default stability filter length
package segmentos_pkg;

  localparam int STABLE_CYCLES_DEF = 4;

  // Segment patterns, active-low, g..a
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // ASCII codes
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_O     = 8'h4F;
  localparam logic [7:0] ASCII_L     = 8'h4C;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_UNK   = 8'h3F;

  localparam int PHRASE_LEN = 16;

  // PHRASE[0] is the first expected symbol; the concatenation lists the
  // phrase back to front so that element 0 lands in the low byte.
  localparam logic [PHRASE_LEN-1:0][7:0] PHRASE = {
    ASCII_SPACE, ASCII_S, ASCII_A, ASCII_S,
    ASCII_O,     ASCII_C, ASCII_DASH, ASCII_A,
    ASCII_L,     ASCII_O, ASCII_S, ASCII_DASH,
    ASCII_O,     ASCII_L, ASCII_O, ASCII_P
  };

  // Matcher FSM
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_MATCH = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/segmentos_decod.sv
// segmentos_decod
// Purely combinational decoder from a 7-segment pattern to ASCII.
// Ports:
//   seg_in [6:0] : active-low pattern, bit6..bit0 = g,f,e,d,c,b,a
//   err          : 1 when the pattern is not one of the known symbols
//   ascii  [7:0] : ASCII code of the symbol, '?' for unknown patterns
module segmentos_decod
  import segmentos_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic       err,
  output logic [7:0] ascii
);

  always_comb begin
    err   = 1'b0;
    ascii = ASCII_UNK;
    case (seg_in)
      SEG_P:     ascii = ASCII_P;
      SEG_O:     ascii = ASCII_O;
      SEG_L:     ascii = ASCII_L;
      SEG_DASH:  ascii = ASCII_DASH;
      SEG_S:     ascii = ASCII_S;
      SEG_A:     ascii = ASCII_A;
      SEG_C:     ascii = ASCII_C;
      SEG_BLANK: ascii = ASCII_SPACE;
      default: begin
        ascii = ASCII_UNK;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/segmentos_a_letras.sv
// segmentos_a_letras
// Debounces a stream of seven-segment patterns, converts each accepted
// symbol to ASCII and detects the phrase "POLO-SOLA-COSAS ".
// Optional feature: define SEG_ERR_CNT_EN to get a saturating counter of
// unknown patterns on err_cnt; otherwise err_cnt is tied to 0.
// Parameters:
//   STABLE_CYCLES : identical valid samples needed to accept a symbol (1..15)
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   seg_in [6:0] : active-low segment pattern (g..a)
//   seg_valid    : seg_in is meaningful this cycle
//   letra  [7:0] : ASCII of the last accepted symbol (held between pulses)
//   letra_valid  : one-cycle pulse, letra/letra_err updated
//   letra_err    : last accepted pattern was not in the table
//   frase_ok     : one-cycle pulse, full phrase received
//   err_cnt[7:0] : saturating count of unknown accepted patterns
module segmentos_a_letras
  import segmentos_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  output logic [7:0] letra,
  output logic       letra_valid,
  output logic       letra_err,
  output logic       frase_ok,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES);

  // ---------------------------------------------------------------
  // Stability filter
  // ---------------------------------------------------------------
  logic [6:0] r_prev;
  logic [3:0] r_run;
  logic [3:0] w_run_next;
  logic       w_same;
  logic       w_hit;
  logic       w_dec_err;
  logic [7:0] w_dec_ascii;

  segmentos_decod u_decod (
    .seg_in (seg_in),
    .err    (w_dec_err),
    .ascii  (w_dec_ascii)
  );

  assign w_same = (seg_in == r_prev);

  always_comb begin
    w_run_next = r_run;
    if (!seg_valid) begin
      w_run_next = 4'd0;
    end else if (w_same) begin
      w_run_next = (r_run == RUN_MAX) ? RUN_MAX : r_run + 4'd1;
    end else begin
      w_run_next = 4'd1;
    end
  end

  // Accept only on the transition into RUN_MAX. A run already saturated
  // and continuing with the same pattern must not fire again; a changed
  // pattern restarts the run, which with STABLE_CYCLES=1 is itself a hit.
  assign w_hit = seg_valid && (w_run_next == RUN_MAX) &&
                 !(w_same && (r_run == RUN_MAX));

  logic [7:0] r_letra;
  logic       r_letra_valid;
  logic       r_letra_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev        <= 7'h7F;
      r_run         <= 4'd0;
      r_letra       <= 8'h00;
      r_letra_valid <= 1'b0;
      r_letra_err   <= 1'b0;
    end else begin
      r_run         <= w_run_next;
      r_letra_valid <= w_hit;
      if (seg_valid) begin
        r_prev <= seg_in;
      end
      if (w_hit) begin
        r_letra     <= w_dec_ascii;
        r_letra_err <= w_dec_err;
      end
    end
  end

  assign letra       = r_letra;
  assign letra_valid = r_letra_valid;
  assign letra_err   = r_letra_err;

  // ---------------------------------------------------------------
  // Phrase matcher: consumes the registered acceptance, so frase_ok
  // (decoded from DONE) lands one cycle after the final letra_valid.
  // ---------------------------------------------------------------
  state_t     r_state, w_state_next;
  logic [3:0] r_pos, w_pos_next;
  logic [3:0] w_pos_base;

  // A symbol arriving while DONE is active is judged from the start.
  assign w_pos_base = (r_state == ST_DONE) ? 4'd0 : r_pos;

  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    if (r_state == ST_DONE) begin
      w_state_next = ST_IDLE;
      w_pos_next   = 4'd0;
    end
    if (r_letra_valid) begin
      if (r_letra_err) begin
        w_state_next = ST_IDLE;
        w_pos_next   = 4'd0;
      end else if (r_letra == PHRASE[w_pos_base]) begin
        if (w_pos_base == 4'(PHRASE_LEN - 1)) begin
          w_state_next = ST_DONE;
          w_pos_next   = 4'd0;
        end else begin
          w_state_next = ST_MATCH;
          w_pos_next   = w_pos_base + 4'd1;
        end
      end else if (r_letra == ASCII_P) begin
        w_state_next = ST_MATCH;
        w_pos_next   = 4'd1;
      end else begin
        w_state_next = ST_IDLE;
        w_pos_next   = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pos   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_pos   <= w_pos_next;
    end
  end

  assign frase_ok = (r_state == ST_DONE);

  // ---------------------------------------------------------------
  // Unknown-pattern counter
  // ---------------------------------------------------------------
`ifdef SEG_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if (r_letra_valid && r_letra_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_segmentos_a_letras.sv
// tb_segmentos_a_letras
// Directed scenarios followed by randomized symbol streams, checked every
// cycle against a symbol-level reference model (run lengths, decode table,
// phrase position).
module tb_segmentos_a_letras;

  localparam int S = 4;
`ifdef SEG_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       seg_valid;
  logic [7:0] letra;
  logic       letra_valid;
  logic       letra_err;
  logic       frase_ok;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  segmentos_a_letras #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .seg_valid   (seg_valid),
    .letra       (letra),
    .letra_valid (letra_valid),
    .letra_err   (letra_err),
    .frase_ok    (frase_ok),
    .err_cnt     (err_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  string      PHR = "POLO-SOLA-COSAS ";
  int         m_k;        // length of current run of identical valid samples
  logic [6:0] m_last;
  int         m_pos;
  int         m_err;
  logic [7:0] m_letra;
  logic       m_lerr;
  logic       m_pend;
  byte        m_pend_ch;
  logic       m_pend_err;
  logic       exp_frase;
  int         lv_cnt = 0;
  int         fo_cnt = 0;

  function automatic logic [6:0] enc(byte c);
    case (c)
      "P": return 7'b0001100;
      "O": return 7'b1000000;
      "L": return 7'b1000111;
      "-": return 7'b0111111;
      "S": return 7'b0010010;
      "A": return 7'b0001000;
      "C": return 7'b1000110;
      " ": return 7'b1111111;
      default: return 7'b1010101;
    endcase
  endfunction

  function automatic byte dec(logic [6:0] p);
    case (p)
      7'b0001100: return "P";
      7'b1000000: return "O";
      7'b1000111: return "L";
      7'b0111111: return "-";
      7'b0010010: return "S";
      7'b0001000: return "A";
      7'b1000110: return "C";
      7'b1111111: return " ";
      default:    return "?";
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_last = 7'h7F; m_pos = 0; m_err = 0;
    m_letra = 8'h00; m_lerr = 1'b0; m_pend = 1'b0; exp_frase = 1'b0;
  endtask

  // One clock cycle with the currently driven inputs, then compare.
  task automatic tick();
    if (!seg_valid)                         m_k = 0;
    else if (m_k > 0 && seg_in == m_last)   m_k = (m_k < 100) ? m_k + 1 : m_k;
    else                                    m_k = 1;
    if (seg_valid) m_last = seg_in;
    @(posedge clk);
    #1;
    // The previous cycle's accepted symbol is consumed at this edge.
    exp_frase = 1'b0;
    if (m_pend) begin
      if (m_pend_err) begin
        m_pos = 0;
        if (ERR_EN && m_err < 255) m_err++;
      end else if (m_pend_ch == PHR[m_pos]) begin
        if (m_pos == 15) begin exp_frase = 1'b1; m_pos = 0; end
        else m_pos++;
      end else begin
        m_pos = (m_pend_ch == "P") ? 1 : 0;
      end
    end
    m_pend = (m_k == S);
    if (m_pend) begin
      m_pend_ch  = dec(seg_in);
      m_pend_err = (m_pend_ch == "?");
      m_letra    = m_pend_ch;
      m_lerr     = m_pend_err;
    end
    check("letra_valid", letra_valid, m_pend);
    check("frase_ok", frase_ok, exp_frase);
    check("letra", letra, m_letra);
    check("letra_err", letra_err, m_lerr);
    check("err_cnt", err_cnt, m_err);
    if (letra_valid) begin
      lv_cnt++;
      $display("[%0t] accept letra=%02h '%c' err=%0b err_cnt=%0d", $time, letra, letra, letra_err, err_cnt);
    end
    if (frase_ok) begin
      fo_cnt++;
      $display("[%0t] frase_ok", $time);
    end
  endtask

  task automatic send_pat(input logic [6:0] p, input int n, input int gap);
    seg_in = p; seg_valid = 1'b1;
    repeat (n) tick();
    seg_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send(input byte c, input int n, input int gap);
    send_pat(enc(c), n, gap);
  endtask

  task automatic send_str(input string s, input int n, input int gap);
    for (int i = 0; i < s.len(); i++) send(s[i], n, gap);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_letra"}, letra, 8'h00);
    check({tag, "_lv"}, letra_valid, 1'b0);
    check({tag, "_lerr"}, letra_err, 1'b0);
    check({tag, "_fo"}, frase_ok, 1'b0);
    check({tag, "_errcnt"}, err_cnt, 8'h00);
  endtask

  int lv0, fo0;

  initial begin
    rst = 1'b1; seg_valid = 1'b0; seg_in = 7'h7F;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Single P held long: exactly one pulse
    lv0 = lv_cnt;
    send("P", 14, 1);
    check("p_pulses", lv_cnt - lv0, 1);
    check("p_letra", letra, 8'h50);

    // O broken by a valid=0 cycle, then a full run
    lv0 = lv_cnt;
    send("O", 3, 1);
    check("o_short_run", lv_cnt - lv0, 0);
    send("O", 4, 1);
    check("o_pulses", lv_cnt - lv0, 1);
    check("o_letra", letra, 8'h4F);

    // Full phrase
    lv0 = lv_cnt; fo0 = fo_cnt;
    send_str(PHR, 5, 1);
    check("phrase_pulses", lv_cnt - lv0, 16);
    check("phrase_frase", fo_cnt - fo0, 1);

    // Unknown pattern in the middle, then the complete phrase
    fo0 = fo_cnt;
    send_str("POL", 5, 1);
    send_pat(7'b1010101, 5, 1);
    check("unk_letra", letra, 8'h3F);
    check("unk_err", letra_err, 1'b1);
    check("unk_frase_early", fo_cnt - fo0, 0);
    send_str(PHR, 5, 1);
    check("unk_errcnt", err_cnt, ERR_EN ? 8'd1 : 8'd0);
    check("unk_frase", fo_cnt - fo0, 1);

    // Partial phrase, restart on P
    fo0 = fo_cnt;
    send_str("POLO-", 5, 1);
    send_str(PHR, 5, 1);
    check("restart_frase", fo_cnt - fo0, 1);

    // Third pass interrupted by asynchronous reset
    fo0 = fo_cnt;
    send_str("POLO-SOL", 5, 1);
    seg_in = enc("A"); seg_valid = 1'b1;
    tick(); tick();
    #1 rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    model_reset();
    @(posedge clk); #1;
    check_outputs_zero("midrst_hold");
    rst = 1'b0;
    check("midrst_frase", fo_cnt - fo0, 0);
    // After release a full run is needed again
    lv0 = lv_cnt;
    send("A", S - 1, 1);
    check("post_rst_short", lv_cnt - lv0, 0);
    send_str("PO", S, 1);

    // Randomized streams, with occasional embedded phrases
    for (int seg = 0; seg < 250; seg++) begin
      string pool;
      pool = "POLSAC- ";
      if ($urandom_range(0, 19) == 0) begin
        send_str(PHR, $urandom_range(S, S + 2), $urandom_range(0, 1));
      end else if ($urandom_range(0, 9) == 0) begin
        send_pat(7'($urandom), $urandom_range(1, 7), $urandom_range(0, 2));
      end else begin
        send(pool[$urandom_range(0, 7)], $urandom_range(1, 7), $urandom_range(0, 2));
      end
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
